// File: rtl/gpio_pkg.sv
// Shared types and constants for the LED sequencer: mode encoding, reload
// patterns and the bit layout of the debounced switch word.
package gpio_pkg;

    localparam int SW_W  = 4;
    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam logic [LED_W-1:0] BLINK_INIT = 4'b1111;
    localparam logic [LED_W-1:0] CHASE_INIT = 4'b0001;
    localparam logic [LED_W-1:0] COUNT_INIT = 4'b0000;

    // Field positions inside the debounced switch word
    localparam int SW_MODE_LSB = 0;
    localparam int SW_MODE_MSB = 1;
    localparam int SW_REVERSE  = 2;
    localparam int SW_PAUSE    = 3;

    // Pattern loaded when entering a mode; MIRROR starts from the switches.
    function automatic logic [LED_W-1:0] init_pattern(input mode_e m,
                                                      input logic [SW_W-1:0] sw);
        logic [LED_W-1:0] p;
        p = sw;
        case (m)
            MODE_BLINK: p = BLINK_INIT;
            MODE_CHASE: p = CHASE_INIT;
            MODE_COUNT: p = COUNT_INIT;
            default:    p = sw;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Board-facing signal bundle of the LED sequencer: raw switches in,
// LED drive, current mode and step pulse out.
interface led_sequencer_if;
    import gpio_pkg::*;

    logic [SW_W-1:0]  gpio_switch;
    logic [LED_W-1:0] gpio_led;
    logic [1:0]       mode;
    logic             step;

    modport master (
        output gpio_switch,
        input  gpio_led,
        input  mode,
        input  step
    );

    modport slave (
        input  gpio_switch,
        output gpio_led,
        output mode,
        output step
    );

endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a whole-vector debouncer: a new value is
// accepted only after it has been seen unchanged for DEBOUNCE_CYCLES cycles.
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg, sync2_reg, prev_reg;
    logic [WIDTH-1:0] db_reg, db_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_base;

    // A fresh synchronised value counts as the first stable cycle of a new run,
    // so any change mid-count discards the partial count.
    always_comb begin
        db_next  = db_reg;
        cnt_next = '0;
        cnt_base = (sync2_reg != prev_reg) ? '0 : cnt_reg;
        if (sync2_reg != db_reg) begin
            if (cnt_base == CNT_LAST) begin
                db_next  = sync2_reg;
                cnt_next = '0;
            end else begin
                cnt_next = cnt_base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
            db_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= sw_raw;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            db_reg    <= db_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign sw_db = db_reg;

endmodule

// File: rtl/led_sequencer.sv
// Switch-controlled LED pattern generator: MIRROR, BLINK, CHASE and COUNT
// modes, stepped by a free-running prescaler and gated by pause.
module led_sequencer
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 32
) (
    input  logic          SYSTEMCLOCK,
    input  logic          RESET,
    led_sequencer_if.slave bus
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [SW_W-1:0]    sw_db;
    mode_e              req_mode;
    mode_e              state_reg, state_next;
    logic [LED_W-1:0]   pattern_reg, pattern_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [LED_W-1:0]   rot_left, rot_right;
    logic               reverse, pause, tick, mode_change, step;

    switch_debounce #(
        .WIDTH           (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (SYSTEMCLOCK),
        .srst   (RESET),
        .sw_raw (bus.gpio_switch),
        .sw_db  (sw_db)
    );

    assign req_mode    = mode_e'(sw_db[SW_MODE_MSB:SW_MODE_LSB]);
    assign reverse     = sw_db[SW_REVERSE];
    assign pause       = sw_db[SW_PAUSE];
    assign tick        = (presc_reg == PRESC_LAST);
    assign mode_change = (req_mode != state_reg);
    assign step        = tick && !pause && !mode_change;

    genvar gi;
    generate
        for (gi = 0; gi < LED_W; gi++) begin : g_rot
            assign rot_left[gi]  = pattern_reg[(gi + LED_W - 1) % LED_W];
            assign rot_right[gi] = pattern_reg[(gi + 1) % LED_W];
        end
    endgenerate

    // A mode change takes priority over a coincident tick: reload and restart.
    always_comb begin
        state_next   = state_reg;
        pattern_next = pattern_reg;
        presc_next   = tick ? '0 : presc_reg + PRESC_W'(1);
        if (mode_change) begin
            state_next   = req_mode;
            pattern_next = init_pattern(req_mode, sw_db);
            presc_next   = '0;
        end else begin
            case (state_reg)
                MODE_MIRROR: pattern_next = sw_db;
                MODE_BLINK:  if (step) pattern_next = ~pattern_reg;
                MODE_CHASE:  if (step) pattern_next = reverse ? rot_right : rot_left;
                MODE_COUNT:  if (step) pattern_next = reverse ? pattern_reg - LED_W'(1)
                                                              : pattern_reg + LED_W'(1);
                default:     pattern_next = pattern_reg;
            endcase
        end
    end

    always_ff @(posedge SYSTEMCLOCK) begin
        if (RESET) begin
            state_reg   <= MODE_MIRROR;
            pattern_reg <= '0;
            presc_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            pattern_reg <= pattern_next;
            presc_reg   <= presc_next;
        end
    end

    assign bus.gpio_led = pattern_reg;
    assign bus.mode     = state_reg;
    assign bus.step     = step;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with DEBOUNCE_CYCLES=4 and TICK_DIV=4;
// inputs change and outputs are sampled on the falling clock edge.
module tb_led_sequencer;

    localparam int DEB  = 4;
    localparam int TDIV = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    led_sequencer_if bus ();

    led_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_DIV        (TDIV)
    ) dut (
        .SYSTEMCLOCK (clk),
        .RESET       (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.gpio_switch = 4'h0;
        wait_cycles(3);
        checks++; if (bus.gpio_led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b expected %b", bus.gpio_led, 4'b0000); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected %0d", bus.mode, 0); end
        checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected %b", bus.step, 1'b0); end
        rst = 1'b0;
        wait_cycles(10);
        checks++; if (bus.gpio_led !== 4'b0000) begin errors++; $display("FAIL idle_led: got %b expected %b", bus.gpio_led, 4'b0000); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL idle_mode: got %0d expected %0d", bus.mode, 0); end
        $display("reset: led=%b mode=%0d", bus.gpio_led, bus.mode);
    endtask

    task automatic test_blink();
        logic [3:0] exp_led;
        logic       exp_step;
        int         pulses;
        pulses = 0;
        bus.gpio_switch = 4'h1;
        wait_cycles(6);
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL blink_early_mode: got %0d expected %0d", bus.mode, 0); end
        wait_cycles(1);
        checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL blink_mode: got %0d expected %0d", bus.mode, 1); end
        checks++; if (bus.gpio_led !== 4'b1111) begin errors++; $display("FAIL blink_init: got %b expected %b", bus.gpio_led, 4'b1111); end
        for (int i = 1; i <= 12; i++) begin
            wait_cycles(1);
            exp_led  = ((i / 4) % 2 == 1) ? 4'b0000 : 4'b1111;
            exp_step = (i % 4 == 3);
            if (bus.step === 1'b1) pulses++;
            checks++; if (bus.gpio_led !== exp_led) begin errors++; $display("FAIL blink_led[%0d]: got %b expected %b", i, bus.gpio_led, exp_led); end
            checks++; if (bus.step !== exp_step) begin errors++; $display("FAIL blink_step[%0d]: got %b expected %b", i, bus.step, exp_step); end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL blink_pulses: got %0d expected %0d", pulses, 3); end
        $display("blink: led=%b pulses=%0d", bus.gpio_led, pulses);
    endtask

    task automatic test_chase();
        logic [3:0] chase_exp [5];
        chase_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.gpio_switch = 4'h2;
        wait_cycles(7);
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL chase_mode: got %0d expected %0d", bus.mode, 2); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) wait_cycles(4);
            checks++; if (bus.gpio_led !== chase_exp[k]) begin errors++; $display("FAIL chase_left[%0d]: got %b expected %b", k, bus.gpio_led, chase_exp[k]); end
        end
        bus.gpio_switch = 4'h6;
        wait_cycles(4);
        checks++; if (bus.gpio_led !== 4'b0010) begin errors++; $display("FAIL chase_pre_rev: got %b expected %b", bus.gpio_led, 4'b0010); end
        wait_cycles(3);
        checks++; if (bus.gpio_led !== 4'b0010) begin errors++; $display("FAIL chase_no_reload: got %b expected %b", bus.gpio_led, 4'b0010); end
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL chase_rev_mode: got %0d expected %0d", bus.mode, 2); end
        wait_cycles(1);
        checks++; if (bus.gpio_led !== 4'b0001) begin errors++; $display("FAIL chase_right0: got %b expected %b", bus.gpio_led, 4'b0001); end
        wait_cycles(4);
        checks++; if (bus.gpio_led !== 4'b1000) begin errors++; $display("FAIL chase_right1: got %b expected %b", bus.gpio_led, 4'b1000); end
        wait_cycles(4);
        checks++; if (bus.gpio_led !== 4'b0100) begin errors++; $display("FAIL chase_right2: got %b expected %b", bus.gpio_led, 4'b0100); end
        $display("chase: led=%b", bus.gpio_led);
    endtask

    task automatic test_count_pause();
        bus.gpio_switch = 4'h7;
        wait_cycles(7);
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL count_mode: got %0d expected %0d", bus.mode, 3); end
        checks++; if (bus.gpio_led !== 4'b0000) begin errors++; $display("FAIL count_init: got %b expected %b", bus.gpio_led, 4'b0000); end
        wait_cycles(4);
        checks++; if (bus.gpio_led !== 4'b1111) begin errors++; $display("FAIL count_down1: got %b expected %b", bus.gpio_led, 4'b1111); end
        wait_cycles(4);
        checks++; if (bus.gpio_led !== 4'b1110) begin errors++; $display("FAIL count_down2: got %b expected %b", bus.gpio_led, 4'b1110); end
        bus.gpio_switch = 4'hF;
        wait_cycles(4);
        checks++; if (bus.gpio_led !== 4'b1101) begin errors++; $display("FAIL pause_last_step: got %b expected %b", bus.gpio_led, 4'b1101); end
        wait_cycles(2);
        for (int i = 6; i <= 20; i++) begin
            if (i > 6) wait_cycles(1);
            checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL pause_step[%0d]: got %b expected %b", i, bus.step, 1'b0); end
            checks++; if (bus.gpio_led !== 4'b1101) begin errors++; $display("FAIL pause_led[%0d]: got %b expected %b", i, bus.gpio_led, 4'b1101); end
        end
        bus.gpio_switch = 4'h7;
        wait_cycles(7);
        checks++; if (bus.step !== 1'b1) begin errors++; $display("FAIL resume_phase: got %b expected %b", bus.step, 1'b1); end
        wait_cycles(1);
        checks++; if (bus.gpio_led !== 4'b1100) begin errors++; $display("FAIL resume_led: got %b expected %b", bus.gpio_led, 4'b1100); end
        $display("count/pause: led=%b", bus.gpio_led);
    endtask

    task automatic test_mirror_glitch();
        bus.gpio_switch = 4'h0;
        wait_cycles(7);
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL mirror_mode: got %0d expected %0d", bus.mode, 0); end
        checks++; if (bus.gpio_led !== 4'b0000) begin errors++; $display("FAIL mirror_init: got %b expected %b", bus.gpio_led, 4'b0000); end
        bus.gpio_switch = 4'h5;
        wait_cycles(3);
        bus.gpio_switch = 4'h0;
        for (int i = 0; i < 15; i++) begin
            wait_cycles(1);
            checks++; if (bus.gpio_led !== 4'b0000 || bus.mode !== 2'd0) begin errors++; $display("FAIL glitch[%0d]: got led=%b mode=%0d expected led=%b mode=%0d", i, bus.gpio_led, bus.mode, 4'b0000, 0); end
        end
        bus.gpio_switch = 4'h8;
        wait_cycles(6);
        checks++; if (bus.gpio_led !== 4'b0000) begin errors++; $display("FAIL mirror_early: got %b expected %b", bus.gpio_led, 4'b0000); end
        wait_cycles(1);
        checks++; if (bus.gpio_led !== 4'b1000) begin errors++; $display("FAIL mirror_latency: got %b expected %b", bus.gpio_led, 4'b1000); end
        wait_cycles(3);
        $display("mirror: led=%b", bus.gpio_led);
    endtask

    task automatic test_tick_collision();
        bus.gpio_switch = 4'h7;
        wait_cycles(7);
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL coll_count_mode: got %0d expected %0d", bus.mode, 3); end
        wait_cycles(1);
        bus.gpio_switch = 4'h2;
        wait_cycles(2);
        checks++; if (bus.step !== 1'b1) begin errors++; $display("FAIL coll_phase: got %b expected %b", bus.step, 1'b1); end
        wait_cycles(1);
        checks++; if (bus.gpio_led !== 4'b1111) begin errors++; $display("FAIL coll_count: got %b expected %b", bus.gpio_led, 4'b1111); end
        wait_cycles(3);
        checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL coll_step: got %b expected %b", bus.step, 1'b0); end
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL coll_mode_before: got %0d expected %0d", bus.mode, 3); end
        wait_cycles(1);
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL coll_mode_after: got %0d expected %0d", bus.mode, 2); end
        checks++; if (bus.gpio_led !== 4'b0001) begin errors++; $display("FAIL coll_init: got %b expected %b", bus.gpio_led, 4'b0001); end
        wait_cycles(3);
        checks++; if (bus.step !== 1'b1) begin errors++; $display("FAIL coll_next_step: got %b expected %b", bus.step, 1'b1); end
        wait_cycles(1);
        checks++; if (bus.gpio_led !== 4'b0010) begin errors++; $display("FAIL coll_next_led: got %b expected %b", bus.gpio_led, 4'b0010); end
        $display("collision: led=%b mode=%0d", bus.gpio_led, bus.mode);
    endtask

    task automatic test_reset_mid_count();
        bus.gpio_switch = 4'h3;
        wait_cycles(7);
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL rmc_mode: got %0d expected %0d", bus.mode, 3); end
        wait_cycles(5);
        checks++; if (bus.gpio_led !== 4'b0001) begin errors++; $display("FAIL rmc_count_up: got %b expected %b", bus.gpio_led, 4'b0001); end
        rst = 1'b1;
        wait_cycles(1);
        checks++; if (bus.gpio_led !== 4'b0000) begin errors++; $display("FAIL rmc_led: got %b expected %b", bus.gpio_led, 4'b0000); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL rmc_mode_rst: got %0d expected %0d", bus.mode, 0); end
        checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL rmc_step: got %b expected %b", bus.step, 1'b0); end
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(6);
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL rmc_redebounce_early: got %0d expected %0d", bus.mode, 0); end
        wait_cycles(1);
        checks++; if (bus.mode !== 2'd3) begin errors++; $display("FAIL rmc_redebounce: got %0d expected %0d", bus.mode, 3); end
        checks++; if (bus.gpio_led !== 4'b0000) begin errors++; $display("FAIL rmc_reinit: got %b expected %b", bus.gpio_led, 4'b0000); end
        $display("reset mid-count: led=%b mode=%0d", bus.gpio_led, bus.mode);
    endtask

    initial begin
        test_reset();
        test_blink();
        test_chase();
        test_count_pause();
        test_mirror_glitch();
        test_tick_collision();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles (2..2^20) before a switch change is accepted.
REQ-002 Parameter TICK_DIV, default 32: SYSTEMCLOCK cycles per pattern step (2..2^24).
REQ-003 SYSTEMCLOCK  in  1  single clock; all state on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 gpio_switch  in  4  raw asynchronous board switches.
REQ-006 gpio_led  out  4  registered LED drive.
REQ-007 mode  out  2  current state encoding (0 MIRROR, 1 BLINK, 2 CHASE, 3 COUNT).
REQ-008 step  out  1  one-cycle pulse on each accepted pattern step.

Function
REQ-009 gpio_switch SHALL pass a 2-flop synchroniser before any other use.
REQ-010 Debounce: the whole 4-bit vector is debounced together; the synchronised value differing from sw_db increments cnt; equality clears cnt; at cnt == DEBOUNCE_CYCLES-1 while still differing, sw_db <= synchronised value and cnt <= 0.
REQ-011 Any change of the synchronised value during counting SHALL restart cnt at 0, so glitches shorter than DEBOUNCE_CYCLES are never accepted.
REQ-012 Field decode of sw_db: [1:0] requested mode, [2] reverse, [3] pause.
REQ-013 Prescaler counts 0..TICK_DIV-1 and wraps; tick asserts for one cycle at TICK_DIV-1; the prescaler runs regardless of pause.
REQ-014 step = tick AND NOT pause AND NOT mode_change; pattern advances only on step.
REQ-015 States: MIRROR, BLINK, CHASE, COUNT; the state SHALL move to the requested mode on the cycle after sw_db[1:0] differs from the current state (mode_change).
REQ-016 On mode_change the pattern loads its initial value: MIRROR sw_db, BLINK 4'b1111, CHASE 4'b0001, COUNT 4'b0000; the prescaler restarts at 0.
REQ-017 Mode change and tick in the same cycle: the mode change wins; the tick is discarded and step stays low.
REQ-018 MIRROR: pattern <= sw_db every cycle, ignoring tick, pause and reverse.
REQ-019 BLINK: on step, pattern <= ~pattern.
REQ-020 CHASE: on step, rotate left (reverse=0) or right (reverse=1); 4'b1000 wraps to 4'b0001 and vice versa.
REQ-021 COUNT: on step, pattern +1 (reverse=0) or -1 (reverse=1), modulo 16 (15->0, 0->15).
REQ-022 A change of reverse or pause alone is not a mode change: no reload, no prescaler restart.
REQ-023 gpio_led = pattern register; pin change to LED latency in MIRROR = 2 + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-024 While RESET is high, on every edge: synchroniser, sw_db, cnt, prescaler and pattern <= 0; state <= MIRROR; gpio_led = 0, mode = 0, step = 0.
REQ-025 Reset asserted mid-debounce or mid-step SHALL discard partial counts; after deassertion, stable non-zero switches need the full debounce time again.

Structure
REQ-026 Shared package gpio_pkg SHALL hold the mode enum, the three initial-pattern constants and the field indices of REQ-012.
REQ-027 Debounce (REQ-009..011) SHALL be a sub-module switch_debounce, parameterised by width and DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=4)
REQ-028 Reset, switches 4'h0 -> gpio_led 0, mode 0; set 4'h1 -> mode 1 and gpio_led 1111 within 7 cycles, then toggling every 4 cycles with one step pulse per toggle.
REQ-029 Switch 4'h2 -> chase 0001,0010,0100,1000,0001; switch 4'h6 -> rotate right from the current value without reload.
REQ-030 Switch 4'h7 -> count down 0000,1111,1110; switch 4'hF -> pattern frozen, step stays 0, prescaler still wraps.
REQ-031 In MIRROR, 3-cycle glitch 0->5->0 -> gpio_led unchanged; held 4'h8 for 10 cycles -> gpio_led 1000 exactly 7 cycles after sampling.
REQ-032 Mode change timed to coincide with tick -> no step pulse, pattern shows the initial value; RESET asserted mid-COUNT -> all outputs 0 next edge.
